condicionador_botoes: RTL and testbench

- Input conditioner between the raw `botoes[3:0]` pins and the game datapath/FSM of the memory game.
- Synchronises, debounces and validates button presses.
- Emits exactly one single-cycle `jogada_feita` pulse per physical press, with the registered one-hot code on `jogada`.
- Multi-button presses are flagged and never delivered as a jogada.

---
 rtl/condicionador_botoes_pkg.sv | 27 ++
 rtl/condicionador_botoes_sincronizador_2ff.sv | 30 +++
 rtl/condicionador_botoes.sv | 106 ++++++++++
 tb/tb_condicionador_botoes.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/condicionador_botoes_pkg.sv
// ---------------------------------------------------------------------------
// condicionador_botoes_pkg: state codes and helpers shared with the hex7seg debug path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package condicionador_botoes_pkg;

  localparam logic [3:0] COD_OCIOSO        = 4'd0;
  localparam logic [3:0] COD_ESTABILIZANDO = 4'd1;
  localparam logic [3:0] COD_REGISTRA      = 4'd2;
  localparam logic [3:0] COD_ESPERA_SOLTAR = 4'd3;

  typedef enum logic [3:0] {
    OCIOSO        = COD_OCIOSO,
    ESTABILIZANDO = COD_ESTABILIZANDO,
    REGISTRA      = COD_REGISTRA,
    ESPERA_SOLTAR = COD_ESPERA_SOLTAR
  } estado_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// ---------------------------------------------------------------------------
// sincronizador_2ff: two-stage synchroniser for asynchronous level inputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] estagio1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estagio1 <= '0;
      q        <= '0;
    end else begin
      estagio1 <= d;
      q        <= estagio1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/condicionador_botoes.sv
// ---------------------------------------------------------------------------
// condicionador_botoes: synchronise, debounce and validate the four game buttons
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic       botao_ativo,
  output logic [3:0] db_estado
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  estado_t          estado;
  logic [CNT_W-1:0] contador;
  logic [3:0]       amostra;
  logic [3:0]       jogada_reg;
  logic [3:0]       botoes_s;

  sincronizador_2ff #(
    .WIDTH(4)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (botoes_s)
  );

  // Pulse flags are set on the edge entering REGISTRA so they are high exactly during it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      contador        <= '0;
      amostra         <= 4'd0;
      jogada_reg      <= 4'd0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      botao_ativo     <= 1'b0;
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (habilita && (botoes_s != 4'd0)) begin
            amostra     <= botoes_s;
            contador    <= '0;
            estado      <= ESTABILIZANDO;
            botao_ativo <= 1'b1;
          end
        end
        ESTABILIZANDO: begin
          if (!habilita || (botoes_s != amostra)) begin
            estado      <= OCIOSO;
            botao_ativo <= 1'b0;
          end else if (contador == LIMITE) begin
            estado          <= REGISTRA;
            jogada_feita    <= is_onehot(amostra);
            jogada_invalida <= !is_onehot(amostra);
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end
        REGISTRA: begin
          if (jogada_feita) begin
            jogada_reg <= amostra;
          end
          contador <= '0;
          estado   <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          // habilita is deliberately ignored so a held button is never re-registered
          if (botoes_s != 4'd0) begin
            contador <= '0;
          end else if (contador == LIMITE) begin
            estado      <= OCIOSO;
            botao_ativo <= 1'b0;
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end
        default: begin
          estado      <= OCIOSO;
          botao_ativo <= 1'b0;
        end
      endcase
    end
  end

  assign jogada    = jogada_feita ? amostra : jogada_reg;
  assign db_estado = estado;

endmodule

`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
// ---------------------------------------------------------------------------
// tb_condicionador_botoes: directed vector table plus multi-cycle sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       botao_ativo;
  logic [3:0] db_estado;

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic       hab;
    logic [3:0] bot;
    logic       feita;
    logic       inval;
    logic [3:0] jog;
    logic [3:0] est;
    logic       ativo;
  } vec_t;

  vec_t tab[$];

  condicionador_botoes #(
    .DEBOUNCE_CYCLES(2),
    .CNT_W          (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .botoes         (botoes),
    .jogada_feita   (jogada_feita),
    .jogada         (jogada),
    .jogada_invalida(jogada_invalida),
    .botao_ativo    (botao_ativo),
    .db_estado      (db_estado)
  );

  always #10 clock = ~clock;

  function automatic logic [10:0] outs();
    return {jogada_feita, jogada_invalida, jogada, db_estado, botao_ativo};
  endfunction

  function automatic logic [10:0] exp_of(input logic f, input logic i, input logic [3:0] j,
                                         input logic [3:0] e, input logic a);
    return {f, i, j, e, a};
  endfunction

  function automatic vec_t mk(input logic h, input logic [3:0] b, input logic f, input logic i,
                              input logic [3:0] j, input logic [3:0] e, input logic a);
    vec_t v;
    v.hab = h; v.bot = b; v.feita = f; v.inval = i; v.jog = j; v.est = e; v.ativo = a;
    return v;
  endfunction

  task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b required %b (feita,inval,jogada,estado,ativo)", nm, got, exp);
  endtask

  task automatic step(input logic h, input logic [3:0] b);
    habilita = h;
    botoes   = b;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    reset    = 1'b0;
    habilita = 1'b0;
    botoes   = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", outs(), 11'd0);
    @(negedge clock);
    reset = 1'b1;

    // single 3-cycle press: pulse visible after edge N+4
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h0, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h0, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h0, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h0, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 1, 0, 4'h1, 4'd2, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    // two buttons together: invalid pulse, jogada retained
    tab.push_back(mk(1, 4'h9, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h9, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h9, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h9, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 0, 1, 4'h1, 4'd2, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    // habilita low: press ignored
    for (int k = 0; k < 5; k++) tab.push_back(mk(0, 4'h8, 0, 0, 4'h1, 4'd0, 0));
    for (int k = 0; k < 2; k++) tab.push_back(mk(0, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    // habilita dropped while stabilising
    tab.push_back(mk(1, 4'h8, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h8, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h8, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(0, 4'h8, 0, 0, 4'h1, 4'd0, 0));
    for (int k = 0; k < 3; k++) tab.push_back(mk(0, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    // bounce then stable segment
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd0, 0));
    tab.push_back(mk(1, 4'h1, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd1, 1));
    tab.push_back(mk(1, 4'h0, 1, 0, 4'h1, 4'd2, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd3, 1));
    tab.push_back(mk(1, 4'h0, 0, 0, 4'h1, 4'd0, 0));

    foreach (tab[i]) begin
      step(tab[i].hab, tab[i].bot);
      check($sformatf("vec%0d", i), outs(),
            exp_of(tab[i].feita, tab[i].inval, tab[i].jog, tab[i].est, tab[i].ativo));
    end

    // held press for 50 cycles: one pulse, then waits for release
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 4'h4);
      if (jogada_feita) pulses++;
      if (k == 4) check("held_registra", outs(), exp_of(1, 0, 4'h4, 4'd2, 1));
      else if (k >= 5) check($sformatf("held_wait%0d", k), outs(), exp_of(0, 0, 4'h4, 4'd3, 1));
    end
    check("held_pulses", 11'(pulses), 11'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'h0);
      check($sformatf("held_release%0d", k), outs(),
            exp_of(0, 0, 4'h4, (k < 3) ? 4'd3 : 4'd0, (k < 3)));
    end

    // reset while waiting for release with button held
    for (int k = 0; k < 7; k++) step(1'b1, 4'h2);
    check("pre_reset_wait", outs(), exp_of(0, 0, 4'h2, 4'd3, 1));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_async", outs(), 11'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'h2);
      if (jogada_feita) pulses++;
      case (k)
        1: check("post_reset_idle", outs(), exp_of(0, 0, 4'h0, 4'd0, 0));
        3: check("post_reset_stab", outs(), exp_of(0, 0, 4'h0, 4'd1, 1));
        4: check("post_reset_reg", outs(), exp_of(1, 0, 4'h2, 4'd2, 1));
        5: check("post_reset_wait", outs(), exp_of(0, 0, 4'h2, 4'd3, 1));
        default: ;
      endcase
    end
    check("post_reset_pulses", 11'(pulses), 11'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 4'h0);
    check("final_idle", outs(), exp_of(0, 0, 4'h2, 4'd0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
